// File: rtl/noc_pkg.sv
// ---------------------------------------------------------------
// noc_pkg: shared NoC flit geometry and field positions
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

package noc_pkg;

  localparam int FLIT_W = 71;
  localparam int DEST_W = 4;
  localparam int NUM_VC = 2;

  localparam int VALID_BIT = 70;
  localparam int HT_BIT    = 69;
  localparam int DEST_HI   = 68;
  localparam int DEST_LO   = 65;
  localparam int VC_BIT    = 64;
  localparam int DATA_HI   = 63;
  localparam int DATA_LO   = 0;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef struct packed {
    logic              valid;
    logic              ht;
    logic [DEST_W-1:0] dest;
    logic              vc;
    logic [63:0]       data;
  } flit_fields_t;

  function automatic logic flit_vc(input flit_t f);
    return f[VC_BIT];
  endfunction

endpackage

`default_nettype wire

// File: rtl/flit_fifo.sv
// ---------------------------------------------------------------
// flit_fifo: synchronous FIFO with full/empty/occupancy outputs
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module flit_fifo #(
  parameter int WIDTH = 71,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_count == CW'(DEPTH));
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];

  // A write into a full FIFO is legal only when a read frees a slot on the same edge.
  assign w_rd = rd_en && !empty;
  assign w_wr = wr_en && (!full || w_rd);

  always_ff @(posedge clk) begin
    if (w_wr && !rst) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pe_flit_injector.sv
// ---------------------------------------------------------------
// pe_flit_injector: queues PE flits and injects them into the router under per-VC credit flow control
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module pe_flit_injector
  import noc_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int CREDITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] pe_flit,
  input  logic              pe_ready_send,
  input  logic [1:0]        credit_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int CRW = $clog2(CREDITS + 1);

  flit_t                  w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_unused_count;
  logic                   w_enq_req;
  logic                   w_enq;
  logic                   w_deq;
  logic                   w_drop;
  logic                   w_head_vc;
  logic [NUM_VC-1:0]      w_has_credit;

  assign w_unused_count = ^w_count;

  assign w_enq_req = pe_ready_send && pe_flit[VALID_BIT] && !rst;
  assign w_head_vc = flit_vc(w_head);
  // Strict FIFO order: only the head is considered, so a starved head blocks both VCs.
  assign w_deq     = !w_empty && w_has_credit[w_head_vc];
  assign w_enq     = w_enq_req && (!w_full || w_deq);
  assign w_drop    = w_enq_req && w_full && !w_deq;

  flit_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_enq),
    .wr_data (pe_flit),
    .rd_en   (w_deq),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    logic [CRW-1:0] r_credit;
    logic           w_dec;

    assign w_dec           = w_deq && (w_head_vc == 1'(v));
    assign w_has_credit[v] = (r_credit != '0);

    // A return and a spend on the same edge cancel out.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_credit <= CRW'(CREDITS);
      end else if (credit_in[v] && !w_dec) begin
        if (r_credit < CRW'(CREDITS)) r_credit <= r_credit + CRW'(1);
      end else if (!credit_in[v] && w_dec) begin
        r_credit <= r_credit - CRW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_out   <= '0;
      flit_valid <= 1'b0;
    end else if (w_deq) begin
      flit_out   <= w_head;
      flit_valid <= 1'b1;
    end else begin
      flit_out   <= '0;
      flit_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (w_drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_flit_injector.sv
// ---------------------------------------------------------------
// tb_pe_flit_injector: scoreboard-based self-checking bench for pe_flit_injector
// Revision 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_pe_flit_injector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [70:0] pe_flit = '0;
  logic        pe_ready_send = 1'b0;
  logic [1:0]  credit_in = 2'b00;
  logic [70:0] flit_out;
  logic        flit_valid;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;
  int tx_count = 0;
  int run = 0;
  int max_run = 0;
  logic [70:0] sb[$];
  logic [70:0] exp_f;

  pe_flit_injector #(.DEPTH(4), .CREDITS(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pe_flit       (pe_flit),
    .pe_ready_send (pe_ready_send),
    .credit_in     (credit_in),
    .flit_out      (flit_out),
    .flit_valid    (flit_valid),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  // Output monitor: every transmitted flit must match the scoreboard head.
  always @(negedge clk) begin
    if (flit_valid) begin
      tx_count++;
      run++;
      if (run > max_run) max_run = run;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL tx_unexpected: flit_out=%h transmitted, none expected", flit_out);
      end else begin
        exp_f = sb.pop_front();
        if (flit_out !== exp_f) begin
          failures++;
          $display("FAIL tx_data: flit_out=%h required %h", flit_out, exp_f);
        end
      end
    end else begin
      run = 0;
      checks++;
      if (flit_out !== '0) begin
        failures++;
        $display("FAIL idle_zero: flit_out=%h required 0", flit_out);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [70:0] mk(input logic vc, input logic [63:0] d);
    return {1'b1, 1'b1, d[3:0], vc, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pe_ready_send = 1'b0;
    credit_in = 2'b00;
    tick(3);
    rst = 1'b0;
  endtask

  task automatic send(input logic [70:0] f, input bit expect_tx);
    pe_flit = f;
    pe_ready_send = 1'b1;
    if (expect_tx) sb.push_back(f);
    tick(1);
    pe_ready_send = 1'b0;
    pe_flit = '0;
  endtask

  task automatic pulse_credit(input int v);
    credit_in[v] = 1'b1;
    tick(1);
    credit_in = 2'b00;
  endtask

  task automatic drain_vc(input logic vc);
    for (int i = 0; i < 4; i++) send(mk(vc, 64'(32'hD000 + i)), 1'b1);
    tick(8);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (flit_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b required 0", flit_valid); end
    checks++; if (flit_out !== '0) begin failures++; $display("FAIL reset_flit_out: got %h required 0", flit_out); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt: got %0d required 0", drop_cnt); end
  endtask

  task automatic test_single();
    logic [70:0] f;
    int n;
    do_reset();
    f = {1'b1, 1'b1, 4'b0101, 1'b0, 64'h6};
    pe_flit = f;
    pe_ready_send = 1'b1;
    sb.push_back(f);
    tick(1);
    pe_ready_send = 1'b0;
    pe_flit = '0;
    checks++; if (flit_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass: flit_valid=%b required 0", flit_valid); end
    tick(1);
    checks++; if (flit_valid !== 1'b1) begin failures++; $display("FAIL single_latency: flit_valid=%b required 1", flit_valid); end
    checks++; if (flit_out !== f) begin failures++; $display("FAIL single_data: flit_out=%h required %h", flit_out, f); end
    tick(2);
    n = tx_count;
    send({1'b0, 1'b1, 4'h3, 1'b0, 64'hBAD}, 1'b0);
    tick(4);
    checks++; if (tx_count != n) begin failures++; $display("FAIL invalid_ignored: tx=%0d required %0d", tx_count - n, 0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    max_run = 0;
    for (int i = 0; i < 4; i++) send(mk(1'(i), 64'(32'hB000 + i)), 1'b1);
    tick(4);
    checks++; if (max_run != 4) begin failures++; $display("FAIL b2b_run: consecutive=%0d required 4", max_run); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL b2b_pending: left=%0d required 0", sb.size()); end
  endtask

  task automatic test_credit_exhaust();
    logic [70:0] f5;
    int n;
    do_reset();
    n = tx_count;
    for (int i = 0; i < 5; i++) send(mk(1'b0, 64'(32'hC000 + i)), 1'b1);
    f5 = mk(1'b0, 64'(32'hC004));
    tick(8);
    checks++; if (tx_count - n != 4) begin failures++; $display("FAIL credit_tx4: tx=%0d required 4", tx_count - n); end
    checks++; if (sb.size() != 1) begin failures++; $display("FAIL credit_hold: pending=%0d required 1", sb.size()); end
    credit_in[0] = 1'b1;
    tick(1);
    credit_in = 2'b00;
    checks++; if (flit_valid !== 1'b0) begin failures++; $display("FAIL credit_early: flit_valid=%b required 0", flit_valid); end
    tick(1);
    checks++; if (flit_valid !== 1'b1 || flit_out !== f5) begin
      failures++; $display("FAIL credit_resume: valid=%b flit_out=%h required 1 %h", flit_valid, flit_out, f5);
    end
    tick(2);
  endtask

  task automatic test_hol();
    int n;
    do_reset();
    drain_vc(1'b1);
    n = tx_count;
    send(mk(1'b1, 64'hA1), 1'b1);
    send(mk(1'b0, 64'hA0), 1'b1);
    tick(8);
    checks++; if (tx_count != n) begin failures++; $display("FAIL hol_block: tx=%0d required 0", tx_count - n); end
    pulse_credit(1);
    tick(6);
    checks++; if (tx_count - n != 2) begin failures++; $display("FAIL hol_release: tx=%0d required 2", tx_count - n); end
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL hol_pending: left=%0d required 0", sb.size()); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    drain_vc(1'b0);
    n = tx_count;
    for (int i = 0; i < 6; i++) send(mk(1'b0, 64'(32'hE000 + i)), i < 4);
    tick(2);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    checks++; if (drop_cnt !== 8'd2) begin failures++; $display("FAIL ovf_drop_cnt: got %0d required 2", drop_cnt); end
    checks++; if (tx_count != n) begin failures++; $display("FAIL ovf_no_tx: tx=%0d required 0", tx_count - n); end
    for (int i = 0; i < 4; i++) pulse_credit(0);
    tick(8);
    checks++; if (tx_count - n != 4) begin failures++; $display("FAIL ovf_tx4: tx=%0d required 4", tx_count - n); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_full_deq();
    logic [70:0] fn;
    do_reset();
    drain_vc(1'b0);
    for (int i = 0; i < 4; i++) send(mk(1'b0, 64'(32'hF000 + i)), 1'b1);
    tick(1);
    credit_in[0] = 1'b1;
    tick(1);
    credit_in = 2'b00;
    fn = mk(1'b0, 64'hF0F0);
    pe_flit = fn;
    pe_ready_send = 1'b1;
    sb.push_back(fn);
    tick(1);
    pe_ready_send = 1'b0;
    pe_flit = '0;
    tick(2);
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL fulldeq_drop_cnt: got %0d required 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fulldeq_overflow: got %b required 0", overflow); end
    for (int i = 0; i < 4; i++) pulse_credit(0);
    tick(8);
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL fulldeq_pending: left=%0d required 0", sb.size()); end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    drain_vc(1'b0);
    for (int i = 0; i < 4; i++) send(mk(1'b0, 64'(32'h5000 + i)), i == 0);
    for (int i = 0; i < 260; i++) send(mk(1'b0, 64'(32'h6000 + i)), 1'b0);
    tick(1);
    checks++; if (drop_cnt !== 8'hFF) begin failures++; $display("FAIL drop_saturate: got %0d required 255", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_credit(0);
    tick(4);
    n = tx_count;
    pe_flit = mk(1'b0, 64'h7777);
    pe_ready_send = 1'b1;
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    pe_ready_send = 1'b0;
    pe_flit = '0;
    tick(10);
    checks++; if (tx_count != n) begin failures++; $display("FAIL rstmid_no_tx: tx=%0d required 0", tx_count - n); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rstmid_overflow: got %b required 0", overflow); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_drop_cnt: got %0d required 0", drop_cnt); end
    n = tx_count;
    for (int i = 0; i < 4; i++) send(mk(1'b0, 64'(32'h8000 + i)), 1'b1);
    for (int i = 0; i < 4; i++) send(mk(1'b1, 64'(32'h9000 + i)), 1'b1);
    tick(10);
    checks++; if (tx_count - n != 8) begin failures++; $display("FAIL rstmid_credits: tx=%0d required 8", tx_count - n); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_credit_exhaust();
    test_hol();
    test_overflow();
    test_full_deq();
    test_drop_saturate();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_pending: left=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
